// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Sequencing controller for the fetch/decode and decode/execute pipeline
// registers of the 16-bit CPU. It decides, every cycle, whether the front of
// the pipeline must stall, whether a NOP bubble is injected into
// decode/execute, whether decode/execute is held, and whether fetch/decode is
// flushed.
//
// Three situations are handled, in priority order while running normally:
//   1. taken branch in execute    -> flush younger instructions (FLUSH state
//                                    keeps bubbling for FLUSH_CYCLES total)
//   2. multi-cycle vector op      -> hold the pipeline until vec_done
//                                    (VEC_WAIT state, with a timeout monitor)
//   3. load-use hazard            -> single bubble cycle, no state change
//
// All control outputs are combinational (Mealy) functions of the current
// state and inputs, so a hazard is acted on in the very cycle it appears.
// They are not gated by reset.
//
// Parameters:
//   FLUSH_CYCLES  bubble cycles inserted after a taken branch (1..7)
//   VEC_TIMEOUT   VEC_WAIT cycles before vec_timeout_err sets (1..65535)
//
// Ports:
//   clk                   clock
//   reset                 synchronous, active-high reset
//   rs1_decode[3:0]       source register 1 of the decode instruction
//   rs2_decode[3:0]       source register 2 of the decode instruction
//   uses_rs1_decode       decode instruction reads rs1
//   uses_rs2_decode       decode instruction reads rs2
//   rd_execute[3:0]       destination register of the execute instruction
//   load_instruction      execute instruction is a load
//   vec_start_execute     multi-cycle vector op present in execute
//   vec_done              vector unit completion pulse
//   branch_taken_execute  branch in execute resolved taken
//   stall_fetch           hold PC and fetch/decode register
//   stall_decode          hold decode-stage state
//   hold_execute          hold decode/execute register contents
//   nop_select            select zero control word into decode/execute
//   flush_fetch_decode    clear fetch/decode register
//   state[1:0]            0=RUN, 1=VEC_WAIT, 2=FLUSH
//   stall_cycles[15:0]    saturating count of cycles with stall_fetch=1
//   vec_timeout_err       sticky vector timeout flag (cleared by reset only)
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned VEC_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rs1_decode,
    input  logic [3:0]  rs2_decode,
    input  logic        uses_rs1_decode,
    input  logic        uses_rs2_decode,
    input  logic [3:0]  rd_execute,
    input  logic        load_instruction,
    input  logic        vec_start_execute,
    input  logic        vec_done,
    input  logic        branch_taken_execute,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        hold_execute,
    output logic        nop_select,
    output logic        flush_fetch_decode,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic        vec_timeout_err
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_VEC_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // The branch cycle itself is the first bubble, so FLUSH only has to
    // cover the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [2:0]  FLUSH_RELOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(VEC_TIMEOUT);
    localparam logic [15:0] COUNT_MAX     = 16'hFFFF;

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        err_q, err_d;

    // -------------------------------------------------------------------------
    // Load-use hazard detection. Each source operand is compared against the
    // load destination independently; register 0 is hardwired and never
    // creates a dependency.
    // -------------------------------------------------------------------------
    logic [3:0] src_reg [2];
    logic [1:0] src_used;
    logic [1:0] src_match;
    logic       load_dest_valid;
    logic       hz;

    assign src_reg[0]  = rs1_decode;
    assign src_reg[1]  = rs2_decode;
    assign src_used[0] = uses_rs1_decode;
    assign src_used[1] = uses_rs2_decode;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = src_used[gi] && (src_reg[gi] == rd_execute);
        end
    endgenerate

    assign load_dest_valid = load_instruction && (rd_execute != 4'd0);
    assign hz              = load_dest_valid && (|src_match);

    // -------------------------------------------------------------------------
    // Next-state and Mealy output decode.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_fetch        = 1'b0;
        stall_decode       = 1'b0;
        hold_execute       = 1'b0;
        nop_select         = 1'b0;
        flush_fetch_decode = 1'b0;
        state_d            = state_q;
        flush_cnt_d        = flush_cnt_q;
        tmo_cnt_d          = tmo_cnt_q;
        err_d              = err_q;

        case (state_q)
            ST_RUN: begin
                if (branch_taken_execute) begin
                    // Branch wins over everything: a vector start or a load
                    // dependency in the same cycle belongs to the wrong path.
                    flush_fetch_decode = 1'b1;
                    nop_select         = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end
                end else if (vec_start_execute) begin
                    // A vector op that completes in its first cycle needs
                    // no hold at all.
                    if (!vec_done) begin
                        stall_fetch  = 1'b1;
                        stall_decode = 1'b1;
                        hold_execute = 1'b1;
                        state_d      = ST_VEC_WAIT;
                        tmo_cnt_d    = 16'd0;
                    end
                end else if (hz) begin
                    // Single bubble: once the load moves on, hz drops by
                    // itself, so no extra state is required.
                    stall_fetch  = 1'b1;
                    stall_decode = 1'b1;
                    nop_select   = 1'b1;
                end
            end

            ST_VEC_WAIT: begin
                if (vec_done) begin
                    state_d = ST_RUN;
                end else begin
                    stall_fetch  = 1'b1;
                    stall_decode = 1'b1;
                    hold_execute = 1'b1;
                    if (tmo_cnt_q != COUNT_MAX) begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                    // Flag only; the pipeline keeps waiting for vec_done.
                    if (tmo_cnt_d >= TIMEOUT_LIMIT) begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                flush_fetch_decode = 1'b1;
                nop_select         = 1'b1;
                if (flush_cnt_q <= 3'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 3'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end

            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    // Stall statistics: saturate instead of wrapping so a long-running
    // system never reports a misleadingly small count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_fetch && (stall_cnt_q != COUNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            tmo_cnt_q   <= 16'd0;
            stall_cnt_q <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign state           = state_q;
    assign stall_cycles    = stall_cnt_q;
    assign vec_timeout_err = err_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Directed scenarios followed by a randomized run. Expected values come from a
// behavioural model that tracks "waiting on a vector op", "bubble cycles still
// owed after a branch", a wait-cycle count, the sticky error and the stall
// total as plain integers.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    localparam int FC = 2;
    localparam int VT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rs1_decode, rs2_decode, rd_execute;
    logic        uses_rs1_decode, uses_rs2_decode;
    logic        load_instruction, vec_start_execute, vec_done;
    logic        branch_taken_execute;
    logic        stall_fetch, stall_decode, hold_execute, nop_select;
    logic        flush_fetch_decode;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic        vec_timeout_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_vec;
    int m_flush_left;
    int m_wait;
    bit m_err;
    int m_stalls;

    // Expected combinational outputs for the current cycle
    bit e_sf, e_sd, e_he, e_nop, e_fl;

    pipeline_hazard_controller #(
        .FLUSH_CYCLES(FC),
        .VEC_TIMEOUT (VT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .rs1_decode          (rs1_decode),
        .rs2_decode          (rs2_decode),
        .uses_rs1_decode     (uses_rs1_decode),
        .uses_rs2_decode     (uses_rs2_decode),
        .rd_execute          (rd_execute),
        .load_instruction    (load_instruction),
        .vec_start_execute   (vec_start_execute),
        .vec_done            (vec_done),
        .branch_taken_execute(branch_taken_execute),
        .stall_fetch         (stall_fetch),
        .stall_decode        (stall_decode),
        .hold_execute        (hold_execute),
        .nop_select          (nop_select),
        .flush_fetch_decode  (flush_fetch_decode),
        .state               (state),
        .stall_cycles        (stall_cycles),
        .vec_timeout_err     (vec_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hz();
        if (!load_instruction || rd_execute == 4'd0) return 1'b0;
        return (uses_rs1_decode && rs1_decode == rd_execute) ||
               (uses_rs2_decode && rs2_decode == rd_execute);
    endfunction

    function automatic int model_state();
        if (m_vec) return 1;
        if (m_flush_left > 0) return 2;
        return 0;
    endfunction

    task automatic model_eval();
        {e_sf, e_sd, e_he, e_nop, e_fl} = 5'b0;
        if (m_vec) begin
            if (!vec_done) {e_sf, e_sd, e_he} = 3'b111;
        end else if (m_flush_left > 0) begin
            e_nop = 1'b1;
            e_fl  = 1'b1;
        end else if (branch_taken_execute) begin
            e_nop = 1'b1;
            e_fl  = 1'b1;
        end else if (vec_start_execute) begin
            if (!vec_done) {e_sf, e_sd, e_he} = 3'b111;
        end else if (model_hz()) begin
            e_sf  = 1'b1;
            e_sd  = 1'b1;
            e_nop = 1'b1;
        end
    endtask

    task automatic model_advance();
        if (reset) begin
            m_vec = 0; m_flush_left = 0; m_wait = 0; m_err = 0; m_stalls = 0;
        end else begin
            if (e_sf && m_stalls < 65535) m_stalls++;
            if (m_vec) begin
                if (vec_done) m_vec = 0;
                else begin
                    if (m_wait < 65535) m_wait++;
                    if (m_wait >= VT) m_err = 1;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (branch_taken_execute) begin
                m_flush_left = FC - 1;
            end else if (vec_start_execute && !vec_done) begin
                m_vec  = 1;
                m_wait = 0;
            end
        end
    endtask

    // One clock: compare mid-cycle, then advance DUT and model together.
    task automatic cycle(input bit chk, input string name);
        #2;
        model_eval();
        if (chk) begin
            check({name, ".stall_fetch"},  32'(stall_fetch),        32'(e_sf));
            check({name, ".stall_decode"}, 32'(stall_decode),       32'(e_sd));
            check({name, ".hold_execute"}, 32'(hold_execute),       32'(e_he));
            check({name, ".nop_select"},   32'(nop_select),         32'(e_nop));
            check({name, ".flush"},        32'(flush_fetch_decode), 32'(e_fl));
            check({name, ".state"},        32'(state),              32'(model_state()));
            check({name, ".stall_cycles"}, 32'(stall_cycles),       32'(m_stalls));
            check({name, ".err"},          32'(vec_timeout_err),    32'(m_err));
            $display("%-10s rst=%0b st=%0d sf=%0b sd=%0b he=%0b nop=%0b fl=%0b cnt=%0d err=%0b",
                     name, reset, state, stall_fetch, stall_decode, hold_execute,
                     nop_select, flush_fetch_decode, stall_cycles, vec_timeout_err);
        end
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle();
        rs1_decode = 0; rs2_decode = 0; rd_execute = 0;
        uses_rs1_decode = 0; uses_rs2_decode = 0;
        load_instruction = 0; vec_start_execute = 0; vec_done = 0;
        branch_taken_execute = 0;
    endtask

    initial begin
        m_vec = 0; m_flush_left = 0; m_wait = 0; m_err = 0; m_stalls = 0;
        reset = 1'b1;
        idle();
        cycle(0, "pre_reset");
        cycle(1, "reset");
        reset = 1'b0;
        cycle(1, "idle");

        // Load-use on rs2, then the same pattern with r0
        load_instruction = 1; rd_execute = 3; rs2_decode = 3; uses_rs2_decode = 1;
        cycle(1, "lu_r3");
        check("lu_cnt", 32'(stall_cycles), 32'd1);
        rd_execute = 0; rs2_decode = 0;
        cycle(1, "lu_r0");
        check("lu_r0_cnt", 32'(stall_cycles), 32'd1);
        idle();
        load_instruction = 1; rd_execute = 7; rs1_decode = 7; uses_rs1_decode = 1;
        cycle(1, "lu_rs1");
        uses_rs1_decode = 0;
        cycle(1, "lu_unused");
        idle();

        // Vector op held, done after 5 stall cycles
        reset = 1'b1; cycle(1, "rst_vec"); reset = 1'b0;
        vec_start_execute = 1;
        for (int i = 0; i < 5; i++) cycle(1, "vec_hold");
        vec_done = 1;
        cycle(1, "vec_done");
        idle();
        cycle(1, "vec_after");
        check("vec_cnt", 32'(stall_cycles), 32'd5);
        check("vec_state", 32'(state), 32'd0);

        // Vector op completing in its first cycle
        vec_start_execute = 1; vec_done = 1;
        cycle(1, "vec_fast");
        idle();
        cycle(1, "vec_fast2");

        // Taken branch
        reset = 1'b1; cycle(1, "rst_br"); reset = 1'b0;
        branch_taken_execute = 1;
        cycle(1, "branch");
        check("br_state", 32'(state), 32'd2);
        branch_taken_execute = 0;
        cycle(1, "flush");
        check("br_ret", 32'(state), 32'd0);
        cycle(1, "br_run");

        // Priority: branch + vector + hazard together
        branch_taken_execute = 1; vec_start_execute = 1;
        load_instruction = 1; rd_execute = 5; rs1_decode = 5; uses_rs1_decode = 1;
        cycle(1, "prio");
        check("prio_state", 32'(state), 32'd2);
        cycle(1, "prio_fl");
        idle();
        cycle(1, "prio_run");
        check("prio_cnt", 32'(stall_cycles), 32'd0);

        // Timeout, then reset in the middle of the wait
        vec_start_execute = 1;
        cycle(1, "tmo_start");
        for (int i = 0; i < 3; i++) cycle(1, "tmo_wait");
        check("tmo_not_yet", 32'(vec_timeout_err), 32'd0);
        cycle(1, "tmo_wait4");
        check("tmo_set", 32'(vec_timeout_err), 32'd1);
        cycle(1, "tmo_more");
        reset = 1'b1;
        cycle(1, "tmo_reset");
        reset = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_err", 32'(vec_timeout_err), 32'd0);
        check("rst_cnt", 32'(stall_cycles), 32'd0);
        idle();
        cycle(1, "post_rst");

        // Reset during FLUSH
        branch_taken_execute = 1;
        cycle(1, "br_pre_rst");
        branch_taken_execute = 0;
        reset = 1'b1;
        cycle(1, "flush_rst");
        reset = 1'b0;
        check("flush_rst_state", 32'(state), 32'd0);

        // Saturation of stall_cycles
        vec_start_execute = 1;
        for (int i = 0; i < 70000; i++) cycle(0, "sat");
        check("sat_cnt", 32'(stall_cycles), 32'hFFFF);
        cycle(1, "sat_chk");
        vec_done = 1;
        cycle(1, "sat_done");
        idle();

        // Randomized traffic
        reset = 1'b1; cycle(1, "rst_rand"); reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rs1_decode           = 4'($urandom_range(0, 3));
            rs2_decode           = 4'($urandom_range(0, 3));
            rd_execute           = 4'($urandom_range(0, 3));
            uses_rs1_decode      = 1'($urandom_range(0, 1));
            uses_rs2_decode      = 1'($urandom_range(0, 1));
            load_instruction     = ($urandom_range(0, 9) < 4);
            vec_start_execute    = ($urandom_range(0, 9) == 0);
            vec_done             = ($urandom_range(0, 9) < 3);
            branch_taken_execute = ($urandom_range(0, 9) == 0);
            reset                = ($urandom_range(0, 99) == 0);
            cycle(1, "rand");
        end
        reset = 1'b0;
        idle();
        cycle(1, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequencing controller for the 16-bit CPU pipeline registers (fetch/decode and decode/execute).
- Detects load-use hazards, stalls fetch/decode and selects the NOP control word into the decode/execute register.
- Holds the pipeline while a multi-cycle vector operation is in execute.
- Flushes younger instructions on a taken branch.
- Keeps a saturating stall-cycle counter and a sticky vector-timeout error.

Parameters:
FLUSH_CYCLES, 2, bubble cycles inserted after a taken branch (legal range 1..7)
VEC_TIMEOUT, 64, cycles in VEC_WAIT before vec_timeout_err sets (legal range 1..65535)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rs1_decode  in  4  source register 1 of the instruction in decode
rs2_decode  in  4  source register 2 of the instruction in decode
uses_rs1_decode  in  1  decode instruction reads rs1
uses_rs2_decode  in  1  decode instruction reads rs2
rd_execute  in  4  destination register of the instruction in execute
load_instruction  in  1  instruction in execute is a load
vec_start_execute  in  1  multi-cycle vector op present in execute
vec_done  in  1  vector unit completion pulse
branch_taken_execute  in  1  branch in execute resolved taken
stall_fetch  out  1  hold PC and fetch/decode register
stall_decode  out  1  hold decode-stage state
hold_execute  out  1  hold decode/execute register contents
nop_select  out  1  NOP mux selects zero control word into decode/execute
flush_fetch_decode  out  1  clear fetch/decode register
state  out  2  0=RUN, 1=VEC_WAIT, 2=FLUSH
stall_cycles  out  16  saturating count of cycles with stall_fetch=1
vec_timeout_err  out  1  sticky vector timeout flag

Behaviour:
- Reset: state=RUN; flush counter, timeout counter, stall_cycles and vec_timeout_err all =0.
- Reset values of the combinational outputs:
  - With all inputs low: stall_fetch, stall_decode, hold_execute, nop_select and flush_fetch_decode are all 0.
  - Reset does not mask the combinational outputs.
- Reset asserted mid-VEC_WAIT or mid-FLUSH returns the controller to RUN on the next edge.
- Outputs are Mealy-combinational from state and inputs; there is no added latency.

Load-use hazard (hz):
- hz = load_instruction & (rd_execute!=0) & ((uses_rs1_decode & rs1_decode==rd_execute) | (uses_rs2_decode & rs2_decode==rd_execute)).
- Register 0 never causes a hazard.

RUN, priority branch > vector > load-use:
- branch_taken_execute=1:
  - Outputs: flush_fetch_decode=1, nop_select=1.
  - If FLUSH_CYCLES>1: go to FLUSH with flush counter = FLUSH_CYCLES-1. Otherwise stay in RUN.
  - vec_start_execute and hz are ignored in this cycle (simultaneous branch and vector start is illegal; branch wins).
- Else vec_start_execute=1:
  - If vec_done=1 in the same cycle: no stall.
  - Otherwise: stall_fetch=1, stall_decode=1, hold_execute=1; next state VEC_WAIT; timeout counter = 0.
- Else hz=1:
  - stall_fetch=1, stall_decode=1, nop_select=1 for exactly one cycle (single bubble); state stays RUN.
  - Next cycle the load has left execute, so hz clears naturally.

VEC_WAIT:
- vec_done=0:
  - stall_fetch=1, stall_decode=1, hold_execute=1, nop_select=0.
  - Timeout counter increments (saturating).
  - When it reaches VEC_TIMEOUT, set vec_timeout_err; the stall continues.
- vec_done=1: all stall outputs 0 this cycle; next state RUN.
- branch_taken_execute is ignored in VEC_WAIT.

FLUSH:
- Outputs: nop_select=1, flush_fetch_decode=1, stall outputs 0.
- Counter decrements each cycle; return to RUN the cycle after the counter reaches 1.
- hz and vec_start_execute are ignored.

stall_cycles:
- Increments on every clock with stall_fetch=1.
- Saturates at 16'hFFFF; no wrap.

vec_timeout_err:
- Cleared only by reset.

Test Plan:
- Load-use: load rd_execute=3, rs2_decode=3, uses_rs2=1 -> one cycle of stall_fetch=stall_decode=nop_select=1; stall_cycles=1; same pattern with rd_execute=0 -> no stall.
- Vector wait: vec_start_execute held, vec_done after 5 cycles -> hold_execute=1 for 5 cycles, released on the vec_done cycle; state 1->0; stall_cycles=5.
- Taken branch, FLUSH_CYCLES=2 -> flush_fetch_decode=nop_select=1 for 2 consecutive cycles; state RUN->FLUSH->RUN.
- Priority: branch_taken_execute, vec_start_execute and hz all asserted -> only flush/nop asserted; stall outputs 0; no VEC_WAIT entry.
- Timeout and reset: VEC_TIMEOUT=4, vec_done never asserted -> vec_timeout_err=1 after 4 wait cycles; reset mid-wait -> state=0, err=0, stall_cycles=0 next cycle.
- Saturation: force 70000 stall cycles -> stall_cycles stays 16'hFFFF.
